controller_hs: RTL and testbench
================================

# controller_hs

Multicycle instruction-sequencing controller for the next-generation 16-bit core. It drives the existing `datapath` control set and adds three things to the current controller:
- a `mem_req`/`mem_ready` handshake, so memory may take any number of cycles;
- a bounded-wait timeout that sends the core to a fault state;
- a HALT state and a parametrised retired-instruction counter.

It sits inside the processor top, between memory and `datapath`.

## Interface
- `MAX_WAIT`, 15: cycles a memory request may stay unanswered before fault (1..255).
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  4  `inst[15:12]` from datapath; `zero`/`neg`  in  1 each, combinational flags of register A.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `s_addr`  out  1  0 = PC, 1 = F; `en_inst`, `en_a`, `en_b`, `en_f`, `en_mdr`, `en_pc`  out  1 each  register enables.
- `alu_op`  out  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 pass A, 7 pass B.
- `s_regfile_din`  out  1  0 = F, 1 = MDR; `we_regfile`  out  1.
- `s_next_pc`  out  1  0 = PC+1, 1 = F.
- `mem_req`  out  1  request valid; `we_mem`  out  1  write qualifier, only with `mem_req`.
- `halted`, `fault`  out  1 each  sticky status.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT: register ops, F = A op B, write back F.
  - 8 LD: F = A+B address, MDR ← mem, write back MDR.
  - 9 ST: F = A+B address, datapath drives B on `dout`.
  - A BZ / B BN: F = B (pass B); if `zero`/`neg`, then PC ← F.
  - C JMP: F = B, PC ← F.
  - F HALT.
  - 6, 7, D, E: NOP (retire, no side effects).
- States and transitions:
  - FETCH: `s_addr`=0, `mem_req`=1, wait for `mem_ready`. On ready: `en_inst`=1, `en_pc`=1, `s_next_pc`=0, go to DECODE.
  - DECODE: `en_a`=`en_b`=1. HALT opcode → HALT; otherwise → EXEC.
  - EXEC: `alu_op` per map, `en_f`=1.
    - LD/ST → MEM.
    - Register ops → WB.
    - Branch/JMP/NOP → FETCH. For taken branches and JMP, `en_pc`=1 with `s_next_pc`=1 in the following FETCH-entry cycle. This is the BR state: one cycle, then FETCH.
  - MEM: `s_addr`=1, `mem_req`=1, `we_mem`=1 for ST. On ready: LD sets `en_mdr`=1 → WB; ST → FETCH.
  - WB: `we_regfile`=1, `s_regfile_din`=1 for LD → FETCH.
  - HALT: all enables 0, `halted`=1; only reset exits.
  - FAULT: all enables 0, `fault`=1; only reset exits.
- Wait counter:
  - Cleared on entering FETCH or MEM; increments each cycle `mem_req`=1 and `mem_ready`=0.
  - Reaching `MAX_WAIT` without ready → FAULT. No register is updated; `mem_req` drops the next cycle.
- `retired` increments by 1 on the last cycle of each instruction: WB, ST-MEM-ready, BR, or EXEC for not-taken branch/NOP. It wraps modulo 2^`CNT_W`. HALT counts once, on entering HALT.
- Outputs are Moore-decoded from the state, except `en_inst`/`en_pc`/`en_mdr` in FETCH/MEM, which are gated by `mem_ready`.

## Timing
- Reset: state FETCH, wait counter 0, `retired` 0, `halted`/`fault` 0. Every enable, `we_regfile` and `we_mem` are 0 in the reset cycle. `mem_req` rises the first cycle after reset deasserts.
- Latency with zero-wait memory (ready in the request cycle):
  - register op 4 cycles;
  - LD 5; ST 4;
  - taken branch/JMP 4; not-taken/NOP 3;
  - HALT 2 to `halted`=1.
- Each wait cycle adds 1. Ready on wait cycle k (k < `MAX_WAIT`) completes normally.
- Holds while `mem_req`=1 and not ready: `s_addr` and `we_mem` stay constant and no enable is asserted.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset mid-request: `mem_req` is 0 the next cycle, with no partial register update.

## Structure
- Shared package `alba_pkg`: the opcode constants, the `alu_op` encodings, and the state enum (FETCH, DECODE, EXEC, MEM, WB, BR, HALT, FAULT).
- One natural sub-module, `wait_timer`: load/clear, count-while-pending, `expired` output, width $clog2(`MAX_WAIT`+1).

## Test plan
- ADD, zero-wait: A=3, B=4 → `we_regfile`=1 exactly at cycle 4 with `alu_op`=0; `retired` 0→1.
- LD, ready after 3 waits: `mem_req` high 4 cycles in MEM, `en_mdr` pulses once on the ready cycle, WB follows with `s_regfile_din`=1. Total 5+3 cycles.
- BZ with `zero`=1, then BN with `neg`=0: first takes `s_next_pc`=1/`en_pc` in BR; second returns to FETCH after EXEC with no PC write. `retired`=2.
- Timeout, `MAX_WAIT`=4, `mem_ready` held 0 in FETCH: `fault`=1 after 4 request cycles, `mem_req`=0 after; the state is stuck until reset.
- HALT then reset: `halted`=1 two cycles after fetch. Assert `reset` 1 cycle → `halted`=0, `retired`=0, fresh FETCH.
- `CNT_W`=4: 17 NOPs → `retired`=1 (wrap). Reset during an ST wait → `we_mem`=0 the next cycle, no write.

Source files
------------

// File: rtl/alba_pkg.sv
// Shared encodings for the 16-bit core: instruction opcodes, ALU operations and
// the sequencing-controller state set.
package alba_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_LD   = 4'h8,
    OP_ST   = 4'h9,
    OP_BZ   = 4'hA,
    OP_BN   = 4'hB,
    OP_JMP  = 4'hC,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_NOT    = 3'd5,
    ALU_PASS_A = 3'd6,
    ALU_PASS_B = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_HALT, S_FAULT
  } state_e;

  // Address arithmetic for LD/ST uses the adder; branch targets come from B.
  function automatic alu_op_e alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD, OP_LD, OP_ST: return ALU_ADD;
      OP_SUB:               return ALU_SUB;
      OP_AND:               return ALU_AND;
      OP_OR:                return ALU_OR;
      OP_XOR:               return ALU_XOR;
      OP_NOT:               return ALU_NOT;
      OP_BZ, OP_BN, OP_JMP: return ALU_PASS_B;
      default:              return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/controller_hs_wait_timer.sv
// Counts unanswered memory-request cycles; flags the cycle that exhausts the
// allowed wait so the controller can fault instead of updating anything.
module wait_timer #(
  parameter int unsigned MAX_WAIT = 15,
  localparam int unsigned W = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic pending,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (pending) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = pending && (cnt_q == LAST);

endmodule

// File: rtl/controller_hs.sv
// Multicycle sequencer for the 16-bit core: drives the datapath control set,
// handshakes with memory, and tracks retired instructions, halt and fault.
module controller_hs
  import alba_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             neg,
  input  logic             mem_ready,
  output logic             s_addr,
  output logic             en_inst,
  output logic             en_a,
  output logic             en_b,
  output logic             en_f,
  output logic             en_mdr,
  output logic             en_pc,
  output logic [2:0]       alu_op,
  output logic             s_regfile_din,
  output logic             we_regfile,
  output logic             s_next_pc,
  output logic             mem_req,
  output logic             we_mem,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             is_ld, is_st, is_reg, is_ctl, taken;
  logic             retire, pending, expired;

  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_reg  = (opcode <= OP_NOT);
  assign is_ctl  = (opcode == OP_BZ) || (opcode == OP_BN) || (opcode == OP_JMP);
  assign taken   = (opcode == OP_JMP) || ((opcode == OP_BZ) && zero) || ((opcode == OP_BN) && neg);
  assign pending = mem_req && !mem_ready;

  // Any state change restarts the wait budget, which covers entry to FETCH and MEM.
  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .pending (pending),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_ld || is_st)       state_d = S_MEM;
        else if (is_reg)          state_d = S_WB;
        else if (is_ctl && taken) state_d = S_BR;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = is_ld ? S_WB : S_FETCH;
          retire  = !is_ld;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB, S_BR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT, S_FAULT: ;
    endcase
  end

  // Moore decode, except the FETCH/MEM enables that wait for mem_ready.
  // Held reset forces everything quiet so no partial update can escape.
  always_comb begin
    s_addr        = 1'b0;
    en_inst       = 1'b0;
    en_a          = 1'b0;
    en_b          = 1'b0;
    en_f          = 1'b0;
    en_mdr        = 1'b0;
    en_pc         = 1'b0;
    alu_op        = ALU_ADD;
    s_regfile_din = 1'b0;
    we_regfile    = 1'b0;
    s_next_pc     = 1'b0;
    mem_req       = 1'b0;
    we_mem        = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          en_inst = mem_ready;
          en_pc   = mem_ready;
        end
        S_DECODE: begin
          en_a = 1'b1;
          en_b = 1'b1;
        end
        S_EXEC: begin
          alu_op = alu_sel(opcode);
          en_f   = is_reg || is_ld || is_st || is_ctl;
        end
        S_MEM: begin
          s_addr  = 1'b1;
          mem_req = 1'b1;
          we_mem  = is_st;
          en_mdr  = is_ld && mem_ready;
        end
        S_WB: begin
          we_regfile    = 1'b1;
          s_regfile_din = is_ld;
        end
        S_BR: begin
          en_pc     = 1'b1;
          s_next_pc = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
      endcase
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_controller_hs.sv
// Directed bench for controller_hs: per-cycle control vectors for each
// instruction class, wait/timeout boundaries, halt, wrap and reset recovery.
module tb_controller_hs;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 4;

  // Bit positions inside ctl, most significant first.
  localparam logic [13:0] S_ADDR  = 14'h2000;
  localparam logic [13:0] EN_INST = 14'h1000;
  localparam logic [13:0] EN_A    = 14'h0800;
  localparam logic [13:0] EN_B    = 14'h0400;
  localparam logic [13:0] EN_F    = 14'h0200;
  localparam logic [13:0] EN_MDR  = 14'h0100;
  localparam logic [13:0] EN_PC   = 14'h0080;
  localparam logic [13:0] S_RDIN  = 14'h0040;
  localparam logic [13:0] WE_RF   = 14'h0020;
  localparam logic [13:0] S_NPC   = 14'h0010;
  localparam logic [13:0] MREQ    = 14'h0008;
  localparam logic [13:0] WE_MEM  = 14'h0004;
  localparam logic [13:0] HALTED  = 14'h0002;
  localparam logic [13:0] FAULT   = 14'h0001;
  localparam logic [13:0] FETCHED = MREQ | EN_INST | EN_PC;
  localparam logic [13:0] DECODED = EN_A | EN_B;

  logic             clk = 1'b0;
  logic             reset, zero, neg, mem_ready;
  logic [3:0]       opcode;
  logic             s_addr, en_inst, en_a, en_b, en_f, en_mdr, en_pc;
  logic [2:0]       alu_op;
  logic             s_regfile_din, we_regfile, s_next_pc, mem_req, we_mem, halted, fault;
  logic [CNT_W-1:0] retired;
  logic [13:0]      ctl;

  int checks   = 0;
  int failures = 0;

  assign ctl = {s_addr, en_inst, en_a, en_b, en_f, en_mdr, en_pc,
                s_regfile_din, we_regfile, s_next_pc, mem_req, we_mem, halted, fault};

  always #5 clk = ~clk;

  controller_hs #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .neg           (neg),
    .mem_ready     (mem_ready),
    .s_addr        (s_addr),
    .en_inst       (en_inst),
    .en_a          (en_a),
    .en_b          (en_b),
    .en_f          (en_f),
    .en_mdr        (en_mdr),
    .en_pc         (en_pc),
    .alu_op        (alu_op),
    .s_regfile_din (s_regfile_din),
    .we_regfile    (we_regfile),
    .s_next_pc     (s_next_pc),
    .mem_req       (mem_req),
    .we_mem        (we_mem),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  task automatic test_reset();
    reset = 1'b1; opcode = 4'h0; zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ctl !== 14'h0) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 14'h0); end
    @(posedge clk); #1;
    checks++;
    if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  // ADD with zero-wait memory; mem_ready stays high outside FETCH and must be ignored.
  task automatic test_add();
    logic [13:0] ef [4] = '{FETCHED, DECODED, EN_F, WE_RF};
    opcode = 4'h0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL add_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      if ((ef[i] & EN_F) != 14'h0) begin
        checks++;
        if (alu_op !== 3'd0) begin failures++; $display("FAIL add_alu got=%0d exp=0", alu_op); end
      end
      if (i == 3) begin
        checks++;
        if (retired !== 4'd0) begin failures++; $display("FAIL add_retired_wb got=%0d exp=0", retired); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 4'd1) begin failures++; $display("FAIL add_retired got=%0d exp=1", retired); end
  endtask

  // LD with three unanswered MEM cycles (one below the timeout limit).
  task automatic test_ld_wait();
    logic [13:0] ef [8] = '{FETCHED, DECODED, EN_F, S_ADDR | MREQ, S_ADDR | MREQ, S_ADDR | MREQ,
                            S_ADDR | MREQ | EN_MDR, WE_RF | S_RDIN};
    logic rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 4'h8;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL ld_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      if ((ef[i] & EN_F) != 14'h0) begin
        checks++;
        if (alu_op !== 3'd0) begin failures++; $display("FAIL ld_alu got=%0d exp=0", alu_op); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 4'd2) begin failures++; $display("FAIL ld_retired got=%0d exp=2", retired); end
  endtask

  // BZ taken, BN not taken, then JMP after one FETCH wait cycle.
  task automatic test_branch();
    logic [3:0]  op  [12] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC, 4'hC, 4'hC, 4'hC, 4'hC};
    logic        rdy [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [13:0] ef  [12] = '{FETCHED, DECODED, EN_F, EN_PC | S_NPC, FETCHED, DECODED, EN_F,
                              MREQ, FETCHED, DECODED, EN_F, EN_PC | S_NPC};
    neg = 1'b0;
    for (int i = 0; i < 12; i++) begin
      opcode = op[i]; mem_ready = rdy[i]; zero = (i < 7);
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL br_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      if ((ef[i] & EN_F) != 14'h0) begin
        checks++;
        if (alu_op !== 3'd7) begin failures++; $display("FAIL br_alu_c%0d got=%0d exp=7", i + 1, alu_op); end
      end
      if (i == 7) begin
        checks++;
        if (retired !== 4'd4) begin failures++; $display("FAIL br_retired_mid got=%0d exp=4", retired); end
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
    checks++;
    if (retired !== 4'd5) begin failures++; $display("FAIL br_retired got=%0d exp=5", retired); end
  endtask

  // ST (zero-wait) immediately followed by OR.
  task automatic test_back_to_back();
    logic [3:0]  op  [8] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h3, 4'h3, 4'h3, 4'h3};
    logic        rdy [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  ea  [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
    logic [13:0] ef  [8] = '{FETCHED, DECODED, EN_F, S_ADDR | MREQ | WE_MEM,
                             FETCHED, DECODED, EN_F, WE_RF};
    for (int i = 0; i < 8; i++) begin
      opcode = op[i]; mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL b2b_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      if ((ef[i] & EN_F) != 14'h0) begin
        checks++;
        if (alu_op !== ea[i]) begin failures++; $display("FAIL b2b_alu_c%0d got=%0d exp=%0d", i + 1, alu_op, ea[i]); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 4'd7) begin failures++; $display("FAIL b2b_retired got=%0d exp=7", retired); end
  endtask

  task automatic test_halt_reset();
    logic        rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [13:0] ef  [4] = '{FETCHED, DECODED, HALTED, HALTED};
    opcode = 4'hF;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL halt_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      if (i == 2) begin
        checks++;
        if (retired !== 4'd8) begin failures++; $display("FAIL halt_retired got=%0d exp=8", retired); end
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 14'h0) begin failures++; $display("FAIL halt_rst_ctl got=%b exp=%b", ctl, 14'h0); end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
    checks++;
    if (retired !== 4'd0) begin failures++; $display("FAIL halt_rst_retired got=%0d exp=0", retired); end
    @(negedge clk);
    checks++;
    if (ctl !== MREQ) begin failures++; $display("FAIL halt_rst_fetch got=%b exp=%b", ctl, MREQ); end
    @(posedge clk); #1;
  endtask

  // Seventeen NOPs through a 4-bit counter; EXEC of a NOP must touch nothing but F.
  task automatic test_nop_wrap();
    logic [3:0]  nops [4] = '{4'h6, 4'h7, 4'hD, 4'hE};
    logic [13:0] ef   [3] = '{FETCHED, DECODED, 14'h0};
    for (int n = 0; n < 17; n++) begin
      opcode = nops[n % 4];
      for (int c = 0; c < 3; c++) begin
        mem_ready = (c == 0);
        @(negedge clk);
        checks++;
        if ((ctl & ~EN_F) !== ef[c]) begin
          failures++; $display("FAIL nop%0d_c%0d got=%b exp=%b", n, c + 1, ctl & ~EN_F, ef[c]);
        end
        @(posedge clk); #1;
      end
      if (n == 15) begin
        checks++;
        if (retired !== 4'd0) begin failures++; $display("FAIL nop_wrap16 got=%0d exp=0", retired); end
      end
    end
    checks++;
    if (retired !== 4'd1) begin failures++; $display("FAIL nop_wrap17 got=%0d exp=1", retired); end
  endtask

  // FETCH never answered: fault after MAX_WAIT request cycles, sticky until reset.
  task automatic test_timeout();
    logic        rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [13:0] ef  [6] = '{MREQ, MREQ, MREQ, MREQ, FAULT, FAULT};
    opcode = 4'h0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL tmo_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (retired !== 4'd1) begin failures++; $display("FAIL tmo_retired got=%0d exp=1", retired); end
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== MREQ) begin failures++; $display("FAIL tmo_rst_fetch got=%b exp=%b", ctl, MREQ); end
    @(posedge clk); #1;
  endtask

  // Reset lands while ST waits; a late mem_ready during reset must not cause a write.
  task automatic test_st_reset();
    logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [13:0] ef  [5] = '{FETCHED, DECODED, EN_F, S_ADDR | MREQ | WE_MEM, S_ADDR | MREQ | WE_MEM};
    opcode = 4'h9;
    checks++;
    if (retired !== 4'd0) begin failures++; $display("FAIL st_retired_start got=%0d exp=0", retired); end
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (ctl !== ef[i]) begin failures++; $display("FAIL st_c%0d got=%b exp=%b", i + 1, ctl, ef[i]); end
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 14'h0) begin failures++; $display("FAIL st_rst_ctl got=%b exp=%b", ctl, 14'h0); end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    checks++;
    if (retired !== 4'd0) begin failures++; $display("FAIL st_rst_retired got=%0d exp=0", retired); end
    @(negedge clk);
    checks++;
    if (ctl !== MREQ) begin failures++; $display("FAIL st_rst_fetch got=%b exp=%b", ctl, MREQ); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_wait();
    test_branch();
    test_back_to_back();
    test_halt_reset();
    test_nop_wrap();
    test_timeout();
    test_st_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
